fib_alu_core: RTL and testbench
===============================

# fib_alu_core

Registered, parametrised successor to the Fibonacci datapath ALU. It holds an internal register file (`NREGS` × `WIDTH`) and executes one opcode per request through a valid/ready handshake. Results are written back into the register file. Zero and carry flags are registered, and a sticky overflow flag is maintained. The block sits between the Fibonacci control FSM, which issues opcodes, and the display/output logic, which reads registers.

## Interface
- `WIDTH`, 4: data width of registers, operands and result.
- `NREGS`, 4: register-file depth; must be a power of two, ≥2. `RW = $clog2(NREGS)`.
- `clk`  in  1  clock, rising edge.
- `reset`  in  1  synchronous, active-high; clears all state.
- `op_valid`  in  1  request present.
- `op_ready`  out  1  block can accept a request (IDLE only).
- `alu_opcode`  in  3  operation, sampled on accept.
- `src_a`, `src_b`  in  RW each  operand register indices, sampled on accept.
- `dst`  in  RW  destination register index, sampled on accept.
- `data_in`  in  WIDTH  external value for LOADX, sampled on accept.
- `op_done`  out  1  one-cycle pulse: writeback completed.
- `result`  out  WIDTH  last written value; holds until the next writeback.
- `zero_flag`  out  1  last written result == 0.
- `carry_flag`  out  1  carry/borrow of the last arithmetic op.
- `ovf_sticky`  out  1  set by any carry/borrow; cleared only by `reset` or `ovf_clr`.
- `ovf_clr`  in  1  clears `ovf_sticky`; a set in the same cycle wins.
- `rd_sel`  in  RW  observation read index.
- `rd_data`  out  WIDTH  combinational `R[rd_sel]`.

## Operation
- Opcodes (`R` = register file; A = `R[src_a]`, B = `R[src_b]`):
  - 000 NOP
  - 001 SET: `R[dst]=1`
  - 010 INC: A+1
  - 011 DEC: A−1
  - 100 LOADX: `data_in`
  - 101 LOAD: A
  - 110 ADD: A+B
  - 111 COPY: B
- Arithmetic is computed at WIDTH+1 bits and truncated to WIDTH.
  - `carry_flag` = bit WIDTH for INC and ADD; borrow (A==0) for DEC.
  - SET, LOAD, LOADX and COPY clear `carry_flag`.
- NOP performs no register write. `zero_flag`, `carry_flag`, `result` and `ovf_sticky` are unchanged, but `op_done` still pulses.
- All non-NOP ops write `R[dst]`, `result` and `zero_flag` at the same edge.
- FSM states: IDLE → EXEC → WB → IDLE.
  - IDLE: `op_ready`=1. `op_valid`&`op_ready` at an edge captures the request and moves to EXEC.
  - EXEC: reads A/B from the register file at this time, computes into internal `res_q`/`cy_q`, moves to WB.
  - WB: at the next edge, writes the register file and flags, pulses `op_done`, returns to IDLE.
- `dst` may equal `src_a`/`src_b`; operands are the pre-write values.
- `op_valid` while not ready is ignored; there is no queueing. The requester holds the request until accepted.

## Timing
- Reset values: all `R`=0, `result`=0, `zero_flag`=1, `carry_flag`=0, `ovf_sticky`=0, `op_done`=0, `op_ready`=1, state IDLE.
- Accept at edge k. Operands are read in the cycle after edge k. Register file and flags are updated at edge k+2.
  - `op_done`=1 and `op_ready`=1 in the cycle following edge k+2.
  - Next accept is possible at edge k+3; throughput is 1 op per 3 cycles.
- `op_ready` is a registered function of state; it does not depend combinationally on `op_valid`.
- `rd_data` shows the new value from the cycle after edge k+2. When `rd_sel`==`dst`, it shows the old value in the cycle before.
- `reset` in EXEC or WB aborts the op: no writeback and no `op_done`, and all state returns to reset values.
- `ovf_clr` takes effect at the next edge. It is ignored at an edge that also sets `ovf_sticky`.

## Structure
- Package `fib_alu_pkg`: opcode localparams (`OP_NOP` … `OP_COPY`) and a state typedef (`ST_IDLE`, `ST_EXEC`, `ST_WB`).
- Sub-module `fib_regfile`:
  - `NREGS`×`WIDTH` storage, synchronous reset.
  - One synchronous write port.
  - Three combinational read ports (A, B, observation).
- The top level contains the FSM, the arithmetic unit, and the flag/result registers.

## Test plan
All scenarios use `WIDTH`=4, `NREGS`=4.
- **Reset:** check reset values. Then `op_valid` with LOADX `dst`=2, `data_in`=7 → `op_done` 3 cycles after accept, `R2`=7, `zero_flag`=0, `carry_flag`=0.
- **Fibonacci:** SET R0, SET R1, then loop ADD R2=R0+R1, COPY R0←R1, COPY R1←R2.
  - R2 sequence: 2, 3, 5, 8, 13.
  - The next ADD gives 21 mod 16 = 5 with `carry_flag`=1 and `ovf_sticky`=1.
- **Borrow:** DEC on R3=0 → `R3`=15, `carry_flag`=1, `zero_flag`=0. Then INC R3 → 0, `zero_flag`=1, `carry_flag`=1.
- **NOP:** after an op leaving `zero_flag`=1, NOP → `op_done` pulses, flags, `result` and all registers unchanged.
- **Handshake:** hold `op_valid` with different opcodes during EXEC/WB → ignored, `op_ready`=0.
  - `ovf_clr` coincident with a carry-producing ADD writeback → `ovf_sticky` stays 1.
  - `ovf_clr` alone at the next edge → `ovf_sticky` = 0.
- **Reset mid-op:** accept ADD, assert `reset` during WB → no `op_done`, `R[dst]`=0, `zero_flag`=1, `op_ready`=1 next cycle.

Source files
------------

// File: rtl/fib_alu_pkg.sv
// Shared opcodes and FSM state encoding for the Fibonacci datapath ALU.
package fib_alu_pkg;

  localparam logic [2:0] OP_NOP   = 3'b000;
  localparam logic [2:0] OP_SET   = 3'b001;
  localparam logic [2:0] OP_INC   = 3'b010;
  localparam logic [2:0] OP_DEC   = 3'b011;
  localparam logic [2:0] OP_LOADX = 3'b100;
  localparam logic [2:0] OP_LOAD  = 3'b101;
  localparam logic [2:0] OP_ADD   = 3'b110;
  localparam logic [2:0] OP_COPY  = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_WB   = 2'd2
  } state_t;

  // Only these ops produce a carry/borrow; all other writes clear the carry flag.
  function automatic logic is_arith(input logic [2:0] op);
    return (op == OP_INC) || (op == OP_DEC) || (op == OP_ADD);
  endfunction

endpackage

// File: rtl/fib_alu_if.sv
// Request/result bundle between the Fibonacci control FSM (master) and the ALU core (slave).
interface fib_alu_if #(
  parameter int WIDTH = 4,
  parameter int NREGS = 4
);
  localparam int RW = $clog2(NREGS);

  logic             op_valid;
  logic             op_ready;
  logic [2:0]       alu_opcode;
  logic [RW-1:0]    src_a;
  logic [RW-1:0]    src_b;
  logic [RW-1:0]    dst;
  logic [WIDTH-1:0] data_in;
  logic             op_done;
  logic [WIDTH-1:0] result;
  logic             zero_flag;
  logic             carry_flag;
  logic             ovf_sticky;
  logic             ovf_clr;
  logic [RW-1:0]    rd_sel;
  logic [WIDTH-1:0] rd_data;

  modport master (
    output op_valid, alu_opcode, src_a, src_b, dst, data_in, ovf_clr, rd_sel,
    input  op_ready, op_done, result, zero_flag, carry_flag, ovf_sticky, rd_data
  );

  modport slave (
    input  op_valid, alu_opcode, src_a, src_b, dst, data_in, ovf_clr, rd_sel,
    output op_ready, op_done, result, zero_flag, carry_flag, ovf_sticky, rd_data
  );

endinterface

// File: rtl/fib_regfile.sv
// NREGS x WIDTH register file: one synchronous write port, three combinational read ports.
module fib_regfile #(
  parameter int WIDTH = 4,
  parameter int NREGS = 4,
  parameter int RW    = $clog2(NREGS)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_we,
  input  logic [RW-1:0]    i_waddr,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic [RW-1:0]    i_raddr_a,
  input  logic [RW-1:0]    i_raddr_b,
  input  logic [RW-1:0]    i_raddr_o,
  output logic [WIDTH-1:0] o_rdata_a,
  output logic [WIDTH-1:0] o_rdata_b,
  output logic [WIDTH-1:0] o_rdata_o
);

  logic [WIDTH-1:0] r_mem [NREGS];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) r_mem[i] <= '0;
    end else if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata_a = r_mem[i_raddr_a];
  assign o_rdata_b = r_mem[i_raddr_b];
  assign o_rdata_o = r_mem[i_raddr_o];

endmodule

// File: rtl/fib_alu_core.sv
// Registered Fibonacci ALU: accept -> EXEC (operand read, compute) -> WB (write-back, flags).
module fib_alu_core
  import fib_alu_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int NREGS = 4
) (
  input  logic   clk,
  input  logic   reset,
  fib_alu_if.slave bus
);

  localparam int RW = $clog2(NREGS);
  localparam logic [WIDTH:0] ONE = (WIDTH+1)'(1);

  state_t           r_state, w_state_nxt;
  logic             w_accept, w_wb, w_we, w_ovf_set;
  logic [2:0]       r_op;
  logic [RW-1:0]    r_src_a, r_src_b, r_dst;
  logic [WIDTH-1:0] r_din;
  logic [WIDTH-1:0] r_res_q;
  logic             r_cy_q;
  logic [WIDTH-1:0] r_result;
  logic             r_zero, r_carry, r_ovf, r_done, r_ready;
  logic [WIDTH-1:0] w_rd_a, w_rd_b;
  logic [WIDTH:0]   w_sum;

  fib_regfile #(.WIDTH(WIDTH), .NREGS(NREGS), .RW(RW)) u_regfile (
    .clk       (clk),
    .reset     (reset),
    .i_we      (w_we),
    .i_waddr   (r_dst),
    .i_wdata   (r_res_q),
    .i_raddr_a (r_src_a),
    .i_raddr_b (r_src_b),
    .i_raddr_o (bus.rd_sel),
    .o_rdata_a (w_rd_a),
    .o_rdata_b (w_rd_b),
    .o_rdata_o (bus.rd_data)
  );

  always_ff @(posedge clk) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_wb        = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (bus.op_valid && r_ready) begin
          w_accept    = 1'b1;
          w_state_nxt = ST_EXEC;
        end
      end
      ST_EXEC: w_state_nxt = ST_WB;
      ST_WB: begin
        w_wb        = 1'b1;
        w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Computed one bit wider so bit WIDTH is the carry (INC/ADD) or borrow (DEC).
  always_comb begin
    w_sum = '0;
    case (r_op)
      OP_SET:   w_sum = ONE;
      OP_INC:   w_sum = {1'b0, w_rd_a} + ONE;
      OP_DEC:   w_sum = {1'b0, w_rd_a} - ONE;
      OP_LOADX: w_sum = {1'b0, r_din};
      OP_LOAD:  w_sum = {1'b0, w_rd_a};
      OP_ADD:   w_sum = {1'b0, w_rd_a} + {1'b0, w_rd_b};
      OP_COPY:  w_sum = {1'b0, w_rd_b};
      default:  w_sum = '0;
    endcase
  end

  assign w_we      = w_wb && (r_op != OP_NOP);
  assign w_ovf_set = w_wb && r_cy_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_op     <= OP_NOP;
      r_src_a  <= '0;
      r_src_b  <= '0;
      r_dst    <= '0;
      r_din    <= '0;
      r_res_q  <= '0;
      r_cy_q   <= 1'b0;
      r_result <= '0;
      r_zero   <= 1'b1;
      r_carry  <= 1'b0;
      r_ovf    <= 1'b0;
      r_done   <= 1'b0;
      r_ready  <= 1'b1;
    end else begin
      if (w_accept) begin
        r_op    <= bus.alu_opcode;
        r_src_a <= bus.src_a;
        r_src_b <= bus.src_b;
        r_dst   <= bus.dst;
        r_din   <= bus.data_in;
      end
      if (r_state == ST_EXEC) begin
        r_res_q <= w_sum[WIDTH-1:0];
        r_cy_q  <= is_arith(r_op) & w_sum[WIDTH];
      end
      if (w_we) begin
        r_result <= r_res_q;
        r_zero   <= (r_res_q == '0);
        r_carry  <= r_cy_q;
      end
      // A set at the same edge overrides a clear request.
      if (w_ovf_set)        r_ovf <= 1'b1;
      else if (bus.ovf_clr) r_ovf <= 1'b0;
      r_done  <= w_wb;
      r_ready <= (w_state_nxt == ST_IDLE);
    end
  end

  assign bus.op_ready   = r_ready;
  assign bus.op_done    = r_done;
  assign bus.result     = r_result;
  assign bus.zero_flag  = r_zero;
  assign bus.carry_flag = r_carry;
  assign bus.ovf_sticky = r_ovf;

endmodule

// File: tb/tb_fib_alu_core.sv
// Directed self-checking bench for fib_alu_core with WIDTH=4, NREGS=4.
module tb_fib_alu_core;
  import fib_alu_pkg::*;

  logic clk = 1'b0;
  logic reset;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  fib_alu_if #(.WIDTH(4), .NREGS(4)) bus ();

  fib_alu_core #(.WIDTH(4), .NREGS(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_reg(input logic [1:0] idx, input logic [3:0] exp);
    bus.rd_sel = idx;
    #1;
    chk($sformatf("R%0d", idx), {28'd0, bus.rd_data}, {28'd0, exp});
  endtask

  // One full transaction; old_v >= 0 also checks that R[d] still reads the old value during WB.
  task automatic run_op(input logic [2:0] op, input logic [1:0] a, input logic [1:0] b,
                        input logic [1:0] d, input logic [3:0] din,
                        input bit hold, input bit clr_wb, input int old_v);
    @(negedge clk);
    chk("ready_idle", {31'd0, bus.op_ready}, 32'd1);
    chk("done_idle", {31'd0, bus.op_done}, 32'd0);
    bus.rd_sel     = d;
    bus.op_valid   = 1'b1;
    bus.alu_opcode = op;
    bus.src_a      = a;
    bus.src_b      = b;
    bus.dst        = d;
    bus.data_in    = din;
    @(posedge clk);
    #1;
    if (hold) begin
      bus.alu_opcode = OP_SET;
      bus.dst        = 2'd0;
    end else begin
      bus.op_valid = 1'b0;
    end
    @(negedge clk);
    chk("ready_exec", {31'd0, bus.op_ready}, 32'd0);
    chk("done_exec", {31'd0, bus.op_done}, 32'd0);
    @(negedge clk);
    chk("ready_wb", {31'd0, bus.op_ready}, 32'd0);
    chk("done_wb", {31'd0, bus.op_done}, 32'd0);
    if (old_v >= 0) chk("rd_old_wb", {28'd0, bus.rd_data}, old_v);
    if (clr_wb) bus.ovf_clr = 1'b1;
    @(posedge clk);
    #1;
    bus.op_valid = 1'b0;
    bus.ovf_clr  = 1'b0;
    @(negedge clk);
    chk("done_pulse", {31'd0, bus.op_done}, 32'd1);
    chk("ready_after", {31'd0, bus.op_ready}, 32'd1);
  endtask

  task automatic chk_flags(input string tag, input logic [3:0] res, input bit z, input bit c, input bit o);
    chk({tag, "_result"}, {28'd0, bus.result}, {28'd0, res});
    chk({tag, "_zero"}, {31'd0, bus.zero_flag}, {31'd0, z});
    chk({tag, "_carry"}, {31'd0, bus.carry_flag}, {31'd0, c});
    chk({tag, "_ovf"}, {31'd0, bus.ovf_sticky}, {31'd0, o});
  endtask

  logic [3:0] fib_exp [5];

  initial begin
    fib_exp[0] = 4'd2; fib_exp[1] = 4'd3; fib_exp[2] = 4'd5; fib_exp[3] = 4'd8; fib_exp[4] = 4'd13;
    reset          = 1'b1;
    bus.op_valid   = 1'b0;
    bus.alu_opcode = OP_NOP;
    bus.src_a      = '0;
    bus.src_b      = '0;
    bus.dst        = '0;
    bus.data_in    = '0;
    bus.ovf_clr    = 1'b0;
    bus.rd_sel     = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_flags("rst", 4'd0, 1'b1, 1'b0, 1'b0);
    chk("rst_done", {31'd0, bus.op_done}, 32'd0);
    chk("rst_ready", {31'd0, bus.op_ready}, 32'd1);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) chk_reg(i[1:0], 4'd0);

    // LOADX R2 = 7; R2 still reads 0 during WB
    run_op(OP_LOADX, 2'd0, 2'd0, 2'd2, 4'd7, 1'b0, 1'b0, 0);
    chk_flags("loadx", 4'd7, 1'b0, 1'b0, 1'b0);
    chk_reg(2'd2, 4'd7);

    // Fibonacci: R0 = R1 = 1, then ADD/COPY/COPY
    run_op(OP_SET, 2'd0, 2'd0, 2'd0, 4'd0, 1'b0, 1'b0, -1);
    run_op(OP_SET, 2'd0, 2'd0, 2'd1, 4'd0, 1'b0, 1'b0, -1);
    chk_flags("set", 4'd1, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 5; k++) begin
      run_op(OP_ADD, 2'd0, 2'd1, 2'd2, 4'd0, 1'b0, 1'b0, -1);
      chk_flags($sformatf("fib%0d", k), fib_exp[k], 1'b0, 1'b0, 1'b0);
      run_op(OP_COPY, 2'd0, 2'd1, 2'd0, 4'd0, 1'b0, 1'b0, -1);
      run_op(OP_COPY, 2'd0, 2'd2, 2'd1, 4'd0, 1'b0, 1'b0, -1);
    end
    chk_reg(2'd0, 4'd8);
    chk_reg(2'd1, 4'd13);
    run_op(OP_ADD, 2'd0, 2'd1, 2'd2, 4'd0, 1'b0, 1'b0, -1);
    chk_flags("fib_wrap", 4'd5, 1'b0, 1'b1, 1'b1);
    chk_reg(2'd2, 4'd5);

    // Borrow then wrap back to zero
    run_op(OP_DEC, 2'd3, 2'd0, 2'd3, 4'd0, 1'b0, 1'b0, -1);
    chk_flags("dec0", 4'd15, 1'b0, 1'b1, 1'b1);
    chk_reg(2'd3, 4'd15);
    run_op(OP_INC, 2'd3, 2'd0, 2'd3, 4'd0, 1'b0, 1'b0, -1);
    chk_flags("inc15", 4'd0, 1'b1, 1'b1, 1'b1);

    // NOP leaves everything untouched
    run_op(OP_NOP, 2'd1, 2'd1, 2'd0, 4'd9, 1'b0, 1'b0, -1);
    chk_flags("nop", 4'd0, 1'b1, 1'b1, 1'b1);
    chk_reg(2'd0, 4'd8);
    chk_reg(2'd1, 4'd13);
    chk_reg(2'd2, 4'd5);
    chk_reg(2'd3, 4'd0);

    // Held valid ignored while busy; ovf_clr loses against a set at the same edge
    run_op(OP_ADD, 2'd1, 2'd0, 2'd3, 4'd0, 1'b1, 1'b1, 0);
    chk_flags("hold_add", 4'd5, 1'b0, 1'b1, 1'b1);
    chk_reg(2'd3, 4'd5);
    chk_reg(2'd0, 4'd8);
    @(negedge clk);
    chk("hold_no_accept", {31'd0, bus.op_ready}, 32'd1);
    bus.ovf_clr = 1'b1;
    @(posedge clk);
    #1;
    bus.ovf_clr = 1'b0;
    @(negedge clk);
    chk("ovf_clr", {31'd0, bus.ovf_sticky}, 32'd0);

    // Reset during WB aborts the write-back
    bus.op_valid   = 1'b1;
    bus.alu_opcode = OP_ADD;
    bus.src_a      = 2'd1;
    bus.src_b      = 2'd1;
    bus.dst        = 2'd2;
    @(posedge clk);
    #1;
    bus.op_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    chk("abort_done", {31'd0, bus.op_done}, 32'd0);
    chk("abort_ready", {31'd0, bus.op_ready}, 32'd1);
    chk_flags("abort", 4'd0, 1'b1, 1'b0, 1'b0);
    chk_reg(2'd2, 4'd0);
    chk_reg(2'd1, 4'd0);
    @(negedge clk);
    chk("abort_done_late", {31'd0, bus.op_done}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
